// File: rtl/fifo_pkg.sv
// fifo_pkg: shared FIFO defaults and write-arbiter state type.
package fifo_pkg;
    localparam int DEF_DATASIZE = 8;
    localparam int DEF_ADDRSIZE = 4;
    localparam int DEF_MAXBURST = 4;
    typedef enum logic {IDLE, GRANT} arb_state_t;
endpackage

// File: rtl/rr_pick.sv
// rr_pick: round-robin search for the first set request after the last owner.
module rr_pick #(
    parameter int NREQ = 4,
    parameter int OW   = 2
) (
    input  logic [NREQ-1:0] i_req,
    input  logic [OW-1:0]   i_last,
    output logic [OW-1:0]   o_next,
    output logic            o_valid
);
    // Scan farthest-first so the nearest set bit after i_last wins.
    always_comb begin
        o_next  = '0;
        o_valid = 1'b0;
        for (int k = NREQ; k >= 1; k--) begin
            if (i_req[(int'(i_last) + k) % NREQ]) begin
                o_next  = OW'((int'(i_last) + k) % NREQ);
                o_valid = 1'b1;
            end
        end
    end
endmodule

// File: rtl/fifo_wr_arb.sv
// fifo_wr_arb: round-robin burst arbiter driving a single FIFO write port.
module fifo_wr_arb import fifo_pkg::*; #(
    parameter int NREQ     = 4,
    parameter int DATASIZE = DEF_DATASIZE,
    parameter int MAXBURST = DEF_MAXBURST,
    localparam int OW      = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic                     wclk,
    input  logic                     wrst,
    input  logic [NREQ-1:0]          req,
    input  logic [NREQ*DATASIZE-1:0] req_data,
    input  logic                     wfull,
    output logic [NREQ-1:0]          gnt,
    output logic                     winc,
    output logic [DATASIZE-1:0]      wdata,
    output logic                     busy,
    output logic [OW-1:0]            owner
);
    arb_state_t r_state, w_state_nx;
    logic [3:0] r_cnt, w_cnt_nx;
    logic [OW-1:0] r_owner, r_last, w_pick;
    logic w_valid, w_act, w_acc;

    rr_pick #(.NREQ(NREQ), .OW(OW)) u_pick (
        .i_req   (req),
        .i_last  (r_last),
        .o_next  (w_pick),
        .o_valid (w_valid)
    );

    // Outputs are masked by wrst so a reset landing mid-burst writes nothing.
    assign w_act = (r_state == GRANT) && !wrst;
    assign w_acc = w_act && req[r_owner] && !wfull;

    always_comb begin
        gnt          = '0;
        gnt[r_owner] = w_acc;
        winc         = w_acc;
        wdata        = w_acc ? req_data[int'(r_owner)*DATASIZE +: DATASIZE] : '0;
        busy         = w_act;
        owner        = wrst ? '0 : r_owner;
    end

    always_comb begin
        w_state_nx = r_state;
        w_cnt_nx   = r_cnt;
        if (r_state == IDLE) begin
            if (w_valid) begin
                w_state_nx = GRANT;
                w_cnt_nx   = '0;
            end
        end else if (!req[r_owner]) begin
            w_state_nx = IDLE;
        end else if (!wfull) begin
            w_cnt_nx   = r_cnt + 4'd1;
            w_state_nx = (w_cnt_nx == 4'(MAXBURST)) ? IDLE : GRANT;
        end
    end

    always_ff @(posedge wclk) begin
        if (wrst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_owner <= '0;
            r_last  <= OW'(NREQ - 1);
        end else begin
            r_state <= w_state_nx;
            r_cnt   <= w_cnt_nx;
            if (r_state == IDLE && w_valid) begin
                r_owner <= w_pick;
                r_last  <= w_pick;
            end
        end
    end
endmodule

// File: tb/tb_fifo_wr_arb.sv
// tb_fifo_wr_arb: directed stimulus with a cycle-stamped beat scoreboard for fifo_wr_arb.
module tb_fifo_wr_arb;
    logic        wclk = 1'b0;
    logic        wrst;
    logic [3:0]  req;
    logic [31:0] req_data;
    logic        wfull;
    logic [3:0]  gnt;
    logic        winc;
    logic [7:0]  wdata;
    logic        busy;
    logic [1:0]  owner;

    typedef struct {int c; logic [3:0] g; logic [7:0] d;} beat_t;
    beat_t q[$];
    int cyc = 0;
    int checks = 0;
    int passes = 0;
    int c0;
    localparam logic [31:0] DATA = {8'h3D, 8'hC7, 8'h5E, 8'hA5};

    fifo_wr_arb dut (
        .wclk     (wclk),
        .wrst     (wrst),
        .req      (req),
        .req_data (req_data),
        .wfull    (wfull),
        .gnt      (gnt),
        .winc     (winc),
        .wdata    (wdata),
        .busy     (busy),
        .owner    (owner)
    );

    always #5 wclk = ~wclk;
    always @(posedge wclk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s cycle %0d: got %0h expected %0h", nm, cyc, act, exp);
    endtask

    task automatic cyc_wait(input int n);
        repeat (n) @(posedge wclk);
        #1;
    endtask

    task automatic exp_beat(input int at, input int idx, input logic [7:0] d);
        beat_t b;
        b.c = at;
        b.g = 4'(1 << idx);
        b.d = d;
        q.push_back(b);
    endtask

    task automatic chk_reset_outs();
        chk("rst_winc", winc, 0);
        chk("rst_gnt", gnt, 0);
        chk("rst_wdata", wdata, 0);
        chk("rst_busy", busy, 0);
        chk("rst_owner", owner, 0);
    endtask

    task automatic do_reset();
        wrst = 1'b1;
        req = '0;
        wfull = 1'b0;
        req_data = DATA;
        cyc_wait(2);
        chk_reset_outs();
        wrst = 1'b0;
    endtask

    // Monitor: every written beat must match the next queued expectation at its exact cycle.
    always @(negedge wclk) begin
        chk("winc_vs_wfull", winc & wfull, 0);
        chk("gnt_onehot", {31'd0, $onehot0(gnt)}, 1);
        chk("winc_eq_or_gnt", winc, |gnt);
        if (!winc) chk("wdata_idle", wdata, 0);
        if (q.size() != 0 && q[0].c == cyc) begin
            chk("beat_winc", winc, 1);
            chk("beat_gnt", gnt, q[0].g);
            chk("beat_wdata", wdata, q[0].d);
            void'(q.pop_front());
        end else begin
            chk("spurious_winc", winc, 0);
        end
    end

    initial begin
        // Single requester: 4 beats, bubble, regrant to the same requester.
        do_reset();
        req = 4'b0001;
        c0 = cyc;
        for (int k = 0; k < 4; k++) exp_beat(c0 + 1 + k, 0, 8'hA5);
        for (int k = 0; k < 4; k++) exp_beat(c0 + 6 + k, 0, 8'hA5);
        cyc_wait(1);
        chk("s1_busy", busy, 1);
        cyc_wait(4);
        chk("s1_bubble_busy", busy, 0);
        cyc_wait(5);
        req = '0;
        cyc_wait(2);

        // All requesters held: 0,1,2,3,0 with one bubble between bursts.
        do_reset();
        req = 4'b1111;
        c0 = cyc;
        for (int b = 0; b < 5; b++)
            for (int k = 0; k < 4; k++)
                exp_beat(c0 + 1 + 5*b + k, b % 4, DATA[(b % 4)*8 +: 8]);
        cyc_wait(11);
        chk("s2_owner2", owner, 2);
        cyc_wait(14);
        req = '0;
        cyc_wait(2);

        // Owner 2 stalled by wfull for 3 cycles after beat 2; data changes before resuming.
        do_reset();
        req = 4'b0100;
        c0 = cyc;
        exp_beat(c0 + 1, 2, 8'hC7);
        exp_beat(c0 + 2, 2, 8'hC7);
        exp_beat(c0 + 6, 2, 8'h99);
        exp_beat(c0 + 7, 2, 8'h99);
        cyc_wait(3);
        wfull = 1'b1;
        #1;
        chk("s3_stall_busy", busy, 1);
        chk("s3_stall_owner", owner, 2);
        chk("s3_stall_winc", winc, 0);
        cyc_wait(3);
        wfull = 1'b0;
        req_data[23:16] = 8'h99;
        cyc_wait(2);
        req = '0;
        cyc_wait(2);

        // Owner 1 drops after 2 beats; requester 2 follows; a new bit 3 does not disturb it.
        do_reset();
        req = 4'b0110;
        c0 = cyc;
        exp_beat(c0 + 1, 1, 8'h5E);
        exp_beat(c0 + 2, 1, 8'h5E);
        for (int k = 0; k < 4; k++) exp_beat(c0 + 5 + k, 2, 8'hC7);
        cyc_wait(3);
        req = 4'b0100;
        cyc_wait(1);
        chk("s4_bubble_busy", busy, 0);
        chk("s4_bubble_owner", owner, 1);
        cyc_wait(2);
        req = 4'b1100;
        cyc_wait(3);
        req = '0;
        cyc_wait(2);

        // Reset pulsed mid-burst of owner 3; requester 0 wins afterwards, then 3.
        do_reset();
        req = 4'b1000;
        c0 = cyc;
        exp_beat(c0 + 1, 3, 8'h3D);
        exp_beat(c0 + 2, 3, 8'h3D);
        for (int k = 0; k < 4; k++) exp_beat(c0 + 5 + k, 0, 8'hA5);
        for (int k = 0; k < 4; k++) exp_beat(c0 + 10 + k, 3, 8'h3D);
        cyc_wait(3);
        wrst = 1'b1;
        req = 4'b1001;
        #1;
        chk_reset_outs();
        cyc_wait(1);
        wrst = 1'b0;
        cyc_wait(10);
        req = '0;
        cyc_wait(3);

        chk("queue_drained", q.size(), 0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule

// File: doc/fifo_wr_arb.md
FIFO_WR_ARB -- requirements
Module: fifo_wr_arb

Interface
REQ-001 Parameter NREQ, default 4, number of write requesters sharing the FIFO write port.
REQ-002 Parameter DATASIZE, default 8, FIFO data width in bits.
REQ-003 Parameter MAXBURST, default 4, maximum accepted beats per grant (range 1..15).
REQ-004 wclk  input  1  single clock; all state updates on rising edge.
REQ-005 wrst  input  1  synchronous, active-high reset.
REQ-006 req  input  NREQ  per-requester write request; bit i held while requester i has data.
REQ-007 req_data  input  NREQ*DATASIZE  requester i data at bits [i*DATASIZE +: DATASIZE].
REQ-008 wfull  input  1  FIFO full flag, write-clock domain.
REQ-009 gnt  output  NREQ  one-hot accept pulse; gnt[i]=1 means req_data slice i is consumed this cycle.
REQ-010 winc  output  1  FIFO write enable.
REQ-011 wdata  output  DATASIZE  FIFO write data.
REQ-012 busy  output  1  high while in GRANT state.
REQ-013 owner  output  clog2(NREQ)  index of current or last granted requester.

Function
REQ-014 The FSM SHALL have two states: IDLE and GRANT.
REQ-015 In IDLE with req nonzero, the next owner SHALL be the first set req bit, searching round-robin from (last owner + 1) mod NREQ; the FSM SHALL enter GRANT on the next edge (one-cycle arbitration latency).
REQ-016 In IDLE, winc and gnt SHALL be 0.
REQ-017 In GRANT, when req[owner]=1 and wfull=0, a beat SHALL be accepted: winc=1, gnt[owner]=1, wdata=req_data slice owner, combinationally in the same cycle.
REQ-018 In GRANT, when wfull=1, winc and gnt SHALL be 0, the beat counter SHALL hold, and the grant SHALL be kept.
REQ-019 A 4-bit beat counter SHALL clear on entry to GRANT and increment on each accepted beat.
REQ-020 GRANT SHALL exit to IDLE on the edge after the accepted beat that brings the count to MAXBURST.
REQ-021 GRANT SHALL exit to IDLE on the edge of any cycle where req[owner]=0; no beat is accepted in that cycle.
REQ-022 Every GRANT-to-IDLE exit SHALL be followed by at least one IDLE cycle (one bubble) before the next grant.
REQ-023 Changes to req bits other than owner SHALL not affect an active grant.
REQ-024 wdata SHALL be 0 whenever winc=0.
REQ-025 gnt SHALL never have more than one bit set, and winc SHALL equal the OR of gnt.

Reset
REQ-026 On wclk edge with wrst=1: state=IDLE, beat counter=0, owner=0, last-owner pointer=NREQ-1, so requester 0 has first priority.
REQ-027 During and after reset: winc=0, gnt=0, wdata=0, busy=0, owner=0.
REQ-028 Reset asserted mid-GRANT SHALL abort the burst immediately, with no winc in the reset cycle.

Structure
REQ-029 A shared package fifo_pkg SHALL hold DATASIZE/ADDRSIZE defaults (8/4), MAXBURST default, and the state enum type arb_state_t {IDLE, GRANT}.
REQ-030 The round-robin next-owner search SHALL be a sub-module rr_pick (combinational: req, last owner -> next owner, valid).
REQ-031 fifo_wr_arb SHALL drive the FIFO write port directly (winc/wdata), with wfull taken from the same FIFO instance.

Verification
REQ-032 Reset then req=4'b0001, data0=8'hA5, wfull=0 -> after 1 IDLE cycle, 4 beats of winc with wdata=A5, gnt=0001, then 1 IDLE bubble, then regrant to requester 0.
REQ-033 req=4'b1111 held continuously -> owners granted in order 0,1,2,3,0, each for 4 beats, with 1 bubble between bursts.
REQ-034 Owner 2 in GRANT, wfull=1 for 3 cycles after beat 2 -> winc=0 for 3 cycles, busy=1, burst then completes beats 3-4 with total winc count 4.
REQ-035 Owner 1 drops req after 2 beats -> exit to IDLE, next grant goes to requester 2 if pending, and owner 1 beat count is 2.
REQ-036 wrst pulsed while owner 3 is mid-burst -> winc=0 in the reset cycle, busy=0, owner=0, and with req=4'b1001 the next grant goes to requester 0.
REQ-037 A scoreboard on all tests SHALL check that the FIFO write sequence equals the gnt-accepted req_data sequence, that winc is never asserted with wfull=1, and that gnt is always one-hot or zero.
